// File: rtl/cam_table.sv
// cam_table: MAC address lookup table with a small command FIFO.
// Match, write and delete commands are captured one per cycle (delete > write
// > match), queued, and executed by a sequential scanner that compares one
// table entry per clock.
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   cam_table_match_valid          pulse: look up cam_table_write_data
//   cam_table_write_data           48-bit MAC key for every command
//   cam_table_write_data_valid     pulse: learn key -> cam_table_index
//   cam_table_index                port index for a write
//   cam_table_delete_key           pulse: invalidate key
//   cam_table_match_index          port of the last hit (held)
//   cam_table_match_enable         one-cycle hit pulse
//   cam_table_no_match             one-cycle miss pulse
//   table_entry_count              number of valid entries
//   command_overflow               one-cycle pulse when a command is dropped
module cam_table #(
    parameter int unsigned NUMBER_OF_PORTS    = 2,
    parameter int unsigned TABLE_DEPTH        = 32,
    parameter int unsigned COMMAND_FIFO_DEPTH = 4
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               cam_table_match_valid,
    input  logic [47:0]                        cam_table_write_data,
    input  logic                               cam_table_write_data_valid,
    input  logic [$clog2(NUMBER_OF_PORTS)-1:0] cam_table_index,
    input  logic                               cam_table_delete_key,
    output logic [$clog2(NUMBER_OF_PORTS)-1:0] cam_table_match_index,
    output logic                               cam_table_match_enable,
    output logic                               cam_table_no_match,
    output logic [$clog2(TABLE_DEPTH):0]       table_entry_count,
    output logic                               command_overflow
);

    localparam int unsigned IW = $clog2(NUMBER_OF_PORTS);
    localparam int unsigned TW = $clog2(TABLE_DEPTH);
    localparam int unsigned FW = $clog2(COMMAND_FIFO_DEPTH);
    localparam int unsigned KW = 48;
    localparam int unsigned CW = 2 + KW + IW;

    typedef enum logic [1:0] {OP_MATCH = 2'd0, OP_WRITE = 2'd1, OP_DELETE = 2'd2} op_e;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_COMMIT = 2'd2} state_e;

    state_e            state, state_next;
    logic [CW-1:0]     fifo_mem [COMMAND_FIFO_DEPTH];
    logic [FW-1:0]     wr_ptr, rd_ptr;
    logic [FW:0]       fifo_cnt;
    logic [KW-1:0]     key_mem  [TABLE_DEPTH];
    logic [IW-1:0]     port_mem [TABLE_DEPTH];
    logic [TABLE_DEPTH-1:0] valid;
    op_e               cmd_op;
    logic [KW-1:0]     cmd_key;
    logic [IW-1:0]     cmd_index;
    logic [TW-1:0]     scan_ptr, hit_idx, free_idx, replace_ptr, target;
    logic              hit_flag, free_flag;

    op_e               in_op;
    logic              in_any, multi, push, pop, fifo_full, fifo_empty;
    logic              hit, last, do_match_hit, do_miss, do_del, do_whit, do_commit;
    logic [CW-1:0]     head;

    // Command capture: pick the highest-priority pulse, flag any dropped one
    always_comb begin
        in_op  = OP_MATCH;
        in_any = 1'b0;
        if (cam_table_delete_key) begin
            in_op  = OP_DELETE;
            in_any = 1'b1;
        end else if (cam_table_write_data_valid) begin
            in_op  = OP_WRITE;
            in_any = 1'b1;
        end else if (cam_table_match_valid) begin
            in_any = 1'b1;
        end
        multi = (2'(cam_table_delete_key) + 2'(cam_table_write_data_valid)
                 + 2'(cam_table_match_valid)) > 2'd1;
    end

    assign fifo_full  = (fifo_cnt == (FW+1)'(COMMAND_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    // A full FIFO still accepts when the scanner pops in the same cycle
    assign push       = in_any && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr];

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FW'(1);
            if (pop)  rd_ptr <= rd_ptr + FW'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + (FW+1)'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - (FW+1)'(1);
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {in_op, cam_table_write_data, cam_table_index};
    end

    assign hit    = valid[scan_ptr] && (key_mem[scan_ptr] == cmd_key);
    assign last   = (scan_ptr == TW'(TABLE_DEPTH - 1));
    // Write target: existing entry, else first free slot, else round-robin victim
    assign target = hit_flag ? hit_idx : (free_flag ? free_idx : replace_ptr);

    // Next-state and control strobes
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        do_match_hit = 1'b0;
        do_miss      = 1'b0;
        do_del       = 1'b0;
        do_whit      = 1'b0;
        do_commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (hit) begin
                    case (cmd_op)
                        OP_MATCH: begin
                            do_match_hit = 1'b1;
                            state_next   = S_IDLE;
                        end
                        OP_DELETE: begin
                            do_del     = 1'b1;
                            state_next = S_IDLE;
                        end
                        default: begin
                            do_whit    = 1'b1;
                            state_next = S_COMMIT;
                        end
                    endcase
                end else if (last) begin
                    do_miss    = (cmd_op == OP_MATCH);
                    state_next = (cmd_op == OP_WRITE) ? S_COMMIT : S_IDLE;
                end
            end
            S_COMMIT: begin
                do_commit  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, scan bookkeeping, valid bits and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= S_IDLE;
            cmd_op                 <= OP_MATCH;
            cmd_key                <= '0;
            cmd_index              <= '0;
            scan_ptr               <= '0;
            hit_flag               <= 1'b0;
            hit_idx                <= '0;
            free_flag              <= 1'b0;
            free_idx               <= '0;
            replace_ptr            <= '0;
            valid                  <= '0;
            table_entry_count      <= '0;
            cam_table_match_index  <= '0;
            cam_table_match_enable <= 1'b0;
            cam_table_no_match     <= 1'b0;
            command_overflow       <= 1'b0;
        end else begin
            state                  <= state_next;
            cam_table_match_enable <= do_match_hit;
            cam_table_no_match     <= do_miss;
            command_overflow       <= multi || (in_any && !push);
            if (do_match_hit) cam_table_match_index <= port_mem[scan_ptr];

            if (pop) begin
                cmd_op    <= op_e'(head[CW-1 -: 2]);
                cmd_key   <= head[IW +: KW];
                cmd_index <= head[IW-1:0];
                scan_ptr  <= '0;
                hit_flag  <= 1'b0;
                free_flag <= 1'b0;
            end else if (state == S_SCAN) begin
                scan_ptr <= scan_ptr + TW'(1);
                if (!valid[scan_ptr] && !free_flag) begin
                    free_flag <= 1'b1;
                    free_idx  <= scan_ptr;
                end
                if (do_whit) begin
                    hit_flag <= 1'b1;
                    hit_idx  <= scan_ptr;
                end
            end

            if (do_del) begin
                valid[scan_ptr]   <= 1'b0;
                table_entry_count <= table_entry_count - (TW+1)'(1);
            end
            if (do_commit) begin
                valid[target] <= 1'b1;
                if (!hit_flag && free_flag)  table_entry_count <= table_entry_count + (TW+1)'(1);
                if (!hit_flag && !free_flag) replace_ptr <= replace_ptr + TW'(1);
            end
        end
    end

    // Key and port storage (no reset; qualified by valid)
    always_ff @(posedge clock) begin
        if (do_commit) begin
            key_mem[target]  <= cmd_key;
            port_mem[target] <= cmd_index;
        end
    end

endmodule
